// File: rtl/sweep_peak_detector_pkg.sv
// Shared types and constants for the sweep peak detector.
//   word_width     : width of the averaged sample stream (signed)
//   peak_idx_width : default width of the sample index / sweep length counters
//   word_t         : signed sample type
//   word_min       : most-negative word_t value, the identity for a running max
//   peak_state_t   : detector FSM states
//   at_least       : signed threshold qualification helper
package sweep_peak_detector_pkg;

    localparam int word_width     = 16;
    localparam int peak_idx_width = 16;

    typedef logic signed [word_width-1:0] word_t;

    localparam word_t word_min = {1'b1, {(word_width-1){1'b0}}};

    typedef enum logic [1:0] {
        PK_IDLE   = 2'd0,
        PK_SCAN   = 2'd1,
        PK_REPORT = 2'd2
    } peak_state_t;

    // Signed "value reaches threshold" test used for peak qualification.
    function automatic logic at_least(input word_t value, input word_t limit);
        return (value >= limit);
    endfunction

endpackage

// File: rtl/sweep_peak_detector_if.sv
// Handshake / data bundle between the sweep controller and the peak detector.
//   master : sweep controller side (drives strobes, threshold, samples; reads result)
//   slave  : peak detector side
// Signals:
//   sweep_start, sweep_stop, abort : single-cycle sweep control strobes
//   threshold                      : signed minimum peak for peak_found
//   sample_in, sample_in_valid     : averaged sample stream
//   busy                           : detector is scanning
//   peak_value, peak_index         : max of the sweep and its first index
//   sweep_len                      : number of valid samples in the sweep
//   peak_found, overflow           : result qualifiers
//   result_valid                   : one-cycle pulse when the result updates
interface sweep_peak_detector_if
    import sweep_peak_detector_pkg::*;
#(
    parameter int IDX_WIDTH = peak_idx_width
) ();

    logic                 sweep_start;
    logic                 sweep_stop;
    logic                 abort;
    word_t                threshold;
    word_t                sample_in;
    logic                 sample_in_valid;
    logic                 busy;
    word_t                peak_value;
    logic [IDX_WIDTH-1:0] peak_index;
    logic [IDX_WIDTH-1:0] sweep_len;
    logic                 peak_found;
    logic                 overflow;
    logic                 result_valid;

    modport master (
        output sweep_start, sweep_stop, abort, threshold, sample_in, sample_in_valid,
        input  busy, peak_value, peak_index, sweep_len, peak_found, overflow, result_valid
    );

    modport slave (
        input  sweep_start, sweep_stop, abort, threshold, sample_in, sample_in_valid,
        output busy, peak_value, peak_index, sweep_len, peak_found, overflow, result_valid
    );

endinterface

// File: rtl/sweep_peak_detector_peak_tracker.sv
// Running-max tracker for one sweep: holds the running maximum, the index of
// its first occurrence and the saturating valid-sample counter.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : start a new sweep (the same-cycle sample is index 0 if enabled)
//   sample   : signed averaged sample
//   valid    : sample qualifier
//   enable   : accept samples this cycle
//   max, idx, count : post-update values (what the registers hold after this edge)
//   sat      : post-update count is at its saturation value
// The outputs are the next-state values so the owner can capture a result on
// the same edge that absorbs the final sample of a sweep.
module peak_tracker
    import sweep_peak_detector_pkg::*;
#(
    parameter int IDX_WIDTH = peak_idx_width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  word_t                sample,
    input  logic                 valid,
    input  logic                 enable,
    output word_t                max,
    output logic [IDX_WIDTH-1:0] idx,
    output logic [IDX_WIDTH-1:0] count,
    output logic                 sat
);

    localparam logic [IDX_WIDTH-1:0] cnt_full = {IDX_WIDTH{1'b1}};
    localparam logic [IDX_WIDTH-1:0] cnt_zero = {IDX_WIDTH{1'b0}};
    localparam logic [IDX_WIDTH-1:0] cnt_one  = IDX_WIDTH'(1);

    word_t                max_r;
    word_t                max_s;
    logic [IDX_WIDTH-1:0] idx_r;
    logic [IDX_WIDTH-1:0] idx_s;
    logic [IDX_WIDTH-1:0] cnt_r;
    logic [IDX_WIDTH-1:0] cnt_s;

    // Next-state of the running max / index / counter.
    always_comb begin
        max_s = max_r;
        idx_s = idx_r;
        cnt_s = cnt_r;
        if (clear) begin
            if (enable && valid) begin
                // Restart inside a sweep: this sample opens the new sweep.
                max_s = sample;
                idx_s = cnt_zero;
                cnt_s = cnt_one;
            end else begin
                max_s = word_min;
                idx_s = cnt_zero;
                cnt_s = cnt_zero;
            end
        end else if (enable && valid && (cnt_r != cnt_full)) begin
            // Strict compare keeps the earliest index on ties.
            if (sample > max_r) begin
                max_s = sample;
                idx_s = cnt_r;
            end else begin
                max_s = max_r;
                idx_s = idx_r;
            end
            cnt_s = cnt_r + cnt_one;
        end else begin
            max_s = max_r;
            idx_s = idx_r;
            cnt_s = cnt_r;
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_r <= word_min;
            idx_r <= cnt_zero;
            cnt_r <= cnt_zero;
        end else begin
            max_r <= max_s;
            idx_r <= idx_s;
            cnt_r <= cnt_s;
        end
    end

    assign max   = max_s;
    assign idx   = idx_s;
    assign count = cnt_s;
    assign sat   = (cnt_s == cnt_full);

endmodule

// File: rtl/sweep_peak_detector.sv
// Sweep peak detector: during a piezo ramp sweep, tracks the signed maximum of
// the averaged samples and where it occurred; at sweep end publishes the peak,
// its index, the sweep length and a threshold-qualified found flag.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : sweep_peak_detector_if slave modport (controls, samples, result)
module sweep_peak_detector
    import sweep_peak_detector_pkg::*;
#(
    parameter int IDX_WIDTH = peak_idx_width
) (
    input  logic                  clk,
    input  logic                  rst,
    sweep_peak_detector_if.slave  bus
);

    localparam logic [IDX_WIDTH-1:0] cnt_zero = {IDX_WIDTH{1'b0}};

    peak_state_t          state_r;
    logic                 busy_r;
    word_t                peak_value_r;
    logic [IDX_WIDTH-1:0] peak_index_r;
    logic [IDX_WIDTH-1:0] sweep_len_r;
    logic                 peak_found_r;
    logic                 overflow_r;
    logic                 result_valid_r;

    logic                 trk_clear_s;
    logic                 trk_enable_s;
    word_t                trk_max_s;
    logic [IDX_WIDTH-1:0] trk_idx_s;
    logic [IDX_WIDTH-1:0] trk_count_s;
    logic                 trk_sat_s;

    // Tracker control: a start clears it in every state except under an abort
    // in SCAN; samples are only taken while scanning.
    always_comb begin
        trk_clear_s  = 1'b0;
        trk_enable_s = 1'b0;
        if (state_r == PK_SCAN) begin
            trk_enable_s = 1'b1;
            trk_clear_s  = bus.sweep_start && !bus.abort;
        end else begin
            trk_enable_s = 1'b0;
            trk_clear_s  = bus.sweep_start;
        end
    end

    peak_tracker #(
        .IDX_WIDTH (IDX_WIDTH)
    ) u_tracker (
        .clk    (clk),
        .rst    (rst),
        .clear  (trk_clear_s),
        .sample (bus.sample_in),
        .valid  (bus.sample_in_valid),
        .enable (trk_enable_s),
        .max    (trk_max_s),
        .idx    (trk_idx_s),
        .count  (trk_count_s),
        .sat    (trk_sat_s)
    );

    // Sweep FSM and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= PK_IDLE;
            busy_r         <= 1'b0;
            peak_value_r   <= word_t'(0);
            peak_index_r   <= cnt_zero;
            sweep_len_r    <= cnt_zero;
            peak_found_r   <= 1'b0;
            overflow_r     <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            case (state_r)
                PK_IDLE: begin
                    if (bus.sweep_start) begin
                        state_r <= PK_SCAN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= PK_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                PK_SCAN: begin
                    if (bus.abort) begin
                        state_r <= PK_IDLE;
                        busy_r  <= 1'b0;
                    end else if (bus.sweep_start) begin
                        state_r <= PK_SCAN;
                        busy_r  <= 1'b1;
                    end else if (bus.sweep_stop || trk_sat_s) begin
                        // Capture the post-update tracker values so a sample
                        // arriving with the stop strobe is part of the result.
                        state_r        <= PK_REPORT;
                        busy_r         <= 1'b0;
                        peak_value_r   <= trk_max_s;
                        peak_index_r   <= trk_idx_s;
                        sweep_len_r    <= trk_count_s;
                        peak_found_r   <= at_least(trk_max_s, bus.threshold) &&
                                          (trk_count_s != cnt_zero);
                        overflow_r     <= trk_sat_s;
                        result_valid_r <= 1'b1;
                    end else begin
                        state_r <= PK_SCAN;
                        busy_r  <= 1'b1;
                    end
                end
                PK_REPORT: begin
                    if (bus.sweep_start) begin
                        state_r <= PK_SCAN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= PK_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= PK_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_r;
    assign bus.peak_value   = peak_value_r;
    assign bus.peak_index   = peak_index_r;
    assign bus.sweep_len    = sweep_len_r;
    assign bus.peak_found   = peak_found_r;
    assign bus.overflow     = overflow_r;
    assign bus.result_valid = result_valid_r;

endmodule

// File: doc/sweep_peak_detector.md
Name: sweep_peak_detector

Overview:
- Downstream consumer of the moving-average stage output stream.
- During each piezo ramp sweep, tracks the signed maximum of the averaged samples and the sample index where it occurred.
- At sweep end, publishes peak value, index, a threshold-qualified "found" flag and the sweep length.
- The OPO lock acquisition logic uses the result to pick the ramp position to lock at.

Parameters:
- IDX_WIDTH, 16, width of the sample index / sweep length counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- sweep_start  in  1  single-cycle strobe: begin (or restart) a sweep
- sweep_stop  in  1  single-cycle strobe: end current sweep
- abort  in  1  drop current sweep, no result
- threshold  in  word_width  signed minimum peak for peak_found
- sample_in  in  word_width  signed averaged sample
- sample_in_valid  in  1  sample qualifier
- busy  out  1  high while in SCAN
- peak_value  out  word_width  signed max of sweep
- peak_index  out  IDX_WIDTH  index (0-based, valid samples only) of first occurrence of max
- sweep_len  out  IDX_WIDTH  number of valid samples in the sweep
- peak_found  out  1  peak_value >= threshold (signed) and sweep_len != 0
- overflow  out  1  sweep ended by index counter saturation
- result_valid  out  1  one-cycle pulse when the result outputs update

Behaviour:
- Reset values: all outputs 0; state IDLE; internal max = most-negative word_width value; counters 0.
- States: IDLE, SCAN, REPORT.
- IDLE:
  - sweep_start -> SCAN; clear the running max to most-negative, the index counter and the running peak index.
  - sweep_stop, abort and samples are ignored.
- SCAN:
  - Each valid sample: if sample_in > running max (signed, strict), running max <= sample_in and running index <= count; then count <= count+1.
  - Ties keep the earliest index.
  - sweep_stop -> REPORT. A valid sample in the same cycle as sweep_stop is included.
  - Count reaching 2^IDX_WIDTH-1 after an increment -> REPORT with overflow=1; later samples are not counted.
  - abort -> IDLE. No result; outputs retain the previous result. abort has priority over stop and start.
  - sweep_start (without abort) restarts: clear as on entry, stay in SCAN; the same-cycle sample is counted as index 0 of the new sweep.
- REPORT, one cycle:
  - Register peak_value, peak_index, sweep_len=count, peak_found, overflow.
  - Pulse result_valid for exactly this cycle.
  - Return to IDLE.
  - A sweep_start in the REPORT cycle is honoured: next state SCAN with clear.
  - Samples in REPORT are dropped.
- Latency: result_valid is asserted the cycle after the cycle in which sweep_stop is sampled in SCAN; outputs are stable from that cycle until the next REPORT.
- Empty sweep (stop with zero samples): peak_value = most-negative, peak_index=0, sweep_len=0, peak_found=0, result_valid pulses.
- busy = (state==SCAN), registered.
- Async reset at any point returns everything to reset values within the reset assertion; no partial result is emitted.
- Arithmetic: all comparisons are signed word_width; no widening needed; index counter saturates, never wraps.

Decomposition:
- opo_package gains:
  - typedef enum peak_state_t {PK_IDLE, PK_SCAN, PK_REPORT};
  - localparam peak_idx_width = 16;
  - localparam word_min = {1'b1,{(word_width-1){1'b0}}}.
- One sub-module: peak_tracker.
  - Holds running max, running index and sample counter.
  - Inputs: clear, sample, valid, enable.
  - Outputs: max, idx, count, sat.
  - The top keeps the FSM and output registers.

Test Plan:
- Start; samples 10, 50, 30, -5; stop -> result_valid one cycle later; peak_value=50, peak_index=1, sweep_len=4, peak_found=1 with threshold=40.
- All-negative sweep -200, -100, -150, threshold=0 -> peak_value=-100, index=1, peak_found=0; confirms signed compare.
- Ties 7, 9, 9, 3 -> peak_index=1. Stop cycle carries valid sample 100 -> included, sweep_len counts it.
- Start then immediate stop with no samples -> sweep_len=0, peak_value=most-negative, peak_found=0. abort mid-sweep -> no result_valid, outputs keep prior result.
- IDX_WIDTH=4, 20 valid samples -> REPORT after count 15, overflow=1, sweep_len=15; sweep_start during REPORT re-enters SCAN.
- Reset asserted mid-SCAN -> all outputs 0, busy=0; a subsequent sweep behaves normally.
